// File: rtl/conv_block_sequencer_pkg.sv
// Shared types and defaults for the convolution block sequencer.
package conv_seq_pkg;

  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PROC  = 3'd3,
    ST_READ  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } seq_state_e;

  localparam int          DEF_NB_IMAGE   = 10;
  localparam int          DEF_NB_BLOCKS  = 8;
  localparam int          DEF_NB_WDOG    = 16;
  localparam logic [15:0] DEF_WDOG_LIMIT = 16'hFFFF;

  // States in which the sequencer waits on the address FSM.
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_LOAD) || (s == ST_PROC) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/conv_block_sequencer_if.sv
// Host-control and address-FSM handshake bundle of the block sequencer.
interface conv_block_sequencer_if #(
  parameter int NB_IMAGE  = conv_seq_pkg::DEF_NB_IMAGE,
  parameter int NB_BLOCKS = conv_seq_pkg::DEF_NB_BLOCKS
);
  logic                 i_start;
  logic                 i_abort;
  logic [NB_IMAGE-1:0]  i_imgLength;
  logic [NB_BLOCKS-1:0] i_nBlocks;
  logic                 i_changeBlock;
  logic                 i_EoP;
  logic                 o_fsmReset;
  logic [NB_IMAGE-1:0]  o_imgLength;
  logic                 o_load;
  logic                 o_SoP;
  logic [NB_BLOCKS-1:0] o_blockIdx;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;

  modport slave (
    input  i_start, i_abort, i_imgLength, i_nBlocks, i_changeBlock, i_EoP,
    output o_fsmReset, o_imgLength, o_load, o_SoP, o_blockIdx, o_busy, o_done, o_error
  );

  modport master (
    output i_start, i_abort, i_imgLength, i_nBlocks, i_changeBlock, i_EoP,
    input  o_fsmReset, o_imgLength, o_load, o_SoP, o_blockIdx, o_busy, o_done, o_error
  );
endinterface

// File: rtl/conv_block_sequencer_seq_rise_det.sv
// Registered rising-edge detector: a rise seen at one edge is flagged for the following cycle.
module seq_rise_det #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o
);
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] rise_q;

  // Delay line and registered edge flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q  <= '0;
      rise_q <= '0;
    end else begin
      sig_q  <= sig_i;
      rise_q <= sig_i & ~sig_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/conv_block_sequencer.sv
// Block-loop scheduler for the 2D-convolution address FSM (load, process, read back per block).
// Optional wait-state watchdog enabled by defining SEQ_WATCHDOG_EN.
module conv_block_sequencer
  import conv_seq_pkg::*;
#(
  parameter int                 NB_IMAGE   = DEF_NB_IMAGE,
  parameter int                 NB_BLOCKS  = DEF_NB_BLOCKS,
  parameter int                 NB_WDOG    = DEF_NB_WDOG,
  parameter logic [NB_WDOG-1:0] WDOG_LIMIT = NB_WDOG'(DEF_WDOG_LIMIT)
) (
  input  logic                   i_CLK,
  input  logic                   i_reset,
  conv_block_sequencer_if.slave  bus
);

  seq_state_e           state_q, state_d;
  logic [NB_IMAGE-1:0]  img_q, img_d;
  logic [NB_BLOCKS-1:0] nblk_q, nblk_d;
  logic [NB_BLOCKS-1:0] idx_q, idx_d;
  logic [NB_BLOCKS-1:0] idx_inc_s;
  logic                 error_q, error_d;
  logic                 fsm_reset_q, load_q, sop_q, busy_q, done_q;
  logic                 cb_rise_s, eop_rise_s;
  logic                 wdog_hit_s;

  seq_rise_det #(.WIDTH(1)) u_cb_rise (
    .clk_i  (i_CLK),
    .rst_ni (i_reset),
    .sig_i  (bus.i_changeBlock),
    .rise_o (cb_rise_s)
  );

  seq_rise_det #(.WIDTH(1)) u_eop_rise (
    .clk_i  (i_CLK),
    .rst_ni (i_reset),
    .sig_i  (bus.i_EoP),
    .rise_o (eop_rise_s)
  );

`ifdef SEQ_WATCHDOG_EN
  logic [NB_WDOG-1:0] wdog_q, wdog_d, wdog_inc_s;

  // Watchdog trips on the cycle the count would reach the limit; restarts on any state change.
  always_comb begin
    wdog_inc_s = wdog_q + NB_WDOG'(1);
    wdog_hit_s = is_wait_state(state_q) && (wdog_inc_s == WDOG_LIMIT);
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (is_wait_state(state_q)) begin
      wdog_d = wdog_inc_s;
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_hit_s = 1'b0;
`endif

  assign idx_inc_s = idx_q + NB_BLOCKS'(1);

  // Next-state and datapath update; abort and watchdog take priority over edge events.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    nblk_d  = nblk_q;
    idx_d   = idx_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          state_d = ST_ARM;
          img_d   = bus.i_imgLength;
          nblk_d  = bus.i_nBlocks;
          idx_d   = '0;
          error_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (bus.i_abort) begin
          state_d = ST_ABORT;
        end else if (nblk_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD, ST_PROC, ST_READ: begin
        if (bus.i_abort || wdog_hit_s) begin
          state_d = ST_ABORT;
          error_d = error_q | wdog_hit_s;
        end else if ((state_q == ST_LOAD) && cb_rise_s) begin
          state_d = ST_PROC;
        end else if ((state_q == ST_PROC) && eop_rise_s) begin
          state_d = ST_READ;
        end else if ((state_q == ST_READ) && cb_rise_s) begin
          idx_d   = idx_inc_s;
          state_d = (idx_inc_s == nblk_q) ? ST_DONE : ST_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration and output registers decoded from the next state.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      img_q       <= '0;
      nblk_q      <= '0;
      idx_q       <= '0;
      error_q     <= 1'b0;
      fsm_reset_q <= 1'b0;
      load_q      <= 1'b0;
      sop_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      nblk_q      <= nblk_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
      fsm_reset_q <= (state_d == ST_ARM) || (state_d == ST_ABORT);
      load_q      <= (state_d == ST_LOAD);
      sop_q       <= (state_d == ST_PROC);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign bus.o_fsmReset  = fsm_reset_q;
  assign bus.o_imgLength = img_q;
  assign bus.o_load      = load_q;
  assign bus.o_SoP       = sop_q;
  assign bus.o_blockIdx  = idx_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_error     = error_q;

endmodule
